// File: rtl/poker_pkg.sv
// Shared encodings for the poker dealing datapath: sequencer states,
// screen codes, card-selection modes and deck size.
package poker_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WAIT   = 3'd1,
        ST_SEARCH = 3'd2,
        ST_EMIT   = 3'd3,
        ST_DONE   = 3'd4
    } deal_state_t;

    localparam logic [1:0] OUTER_RESET = 2'd0;
    localparam logic [1:0] OUTER_DEAL  = 2'd1;
    localparam logic [1:0] OUTER_DONE  = 2'd2;

    localparam logic [1:0] CHOOSE_NONE = 2'd0;
    localparam logic [1:0] CHOOSE_SEQ  = 2'd1;
    localparam logic [1:0] CHOOSE_RAND = 2'd2;

    localparam logic [5:0] NUM_CARDS = 6'd52;

endpackage

// File: rtl/lfsr8.sv
// Free-running 8-bit Fibonacci LFSR, polynomial x^8+x^6+x^5+x^4+1.
// The polynomial is primitive, so a nonzero seed walks all 255 nonzero states.
module lfsr8 #(
    parameter logic [7:0] SEED = 8'h01
) (
    input  logic       clk,
    input  logic       rst,
    output logic [7:0] state
);

    logic [7:0] state_reg;
    logic       feedback;

    assign feedback = state_reg[7] ^ state_reg[5] ^ state_reg[4] ^ state_reg[3];
    assign state    = state_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= SEED;
        end else begin
            state_reg <= {state_reg[6:0], feedback};
        end
    end

endmodule

// File: rtl/deal_sequencer.sv
// Card-dealing sequencer: paces one dealt card per DEAL_INTERVAL frame ticks,
// picking cards in order or at random without repeats from a 52-bit used map.
module deal_sequencer
    import poker_pkg::*;
#(
    parameter int         DEAL_INTERVAL = 30,
    parameter logic [7:0] LFSR_SEED     = 8'h01
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_seq,
    input  logic       btn_rand,
    input  logic       btn_deal,
    input  logic       btn_clear,
    input  logic       frame_tick,
    output logic [1:0] outer_state,
    output logic [1:0] choose,
    output logic       card_valid,
    output logic [5:0] card_id,
    output logic [1:0] player,
    output logic [5:0] deal_cnt
);

    localparam logic [7:0] TICK_LAST = 8'(DEAL_INTERVAL - 1);

    deal_state_t          state_reg, state_next;
    logic [1:0]           choose_reg, choose_next;
    logic [NUM_CARDS-1:0] used_reg, used_next;
    logic [5:0]           deal_cnt_reg, deal_cnt_next;
    logic [7:0]           tick_cnt_reg, tick_cnt_next;
    logic [5:0]           card_id_reg, card_id_next;
    logic [1:0]           player_reg, player_next;

    logic [7:0] lfsr_state;
    logic [5:0] candidate;
    logic       cand_in_range;
    logic       cand_accept;

    lfsr8 #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .state (lfsr_state)
    );

    // Random candidates above the deck size are rejected before the used map is consulted.
    always_comb begin
        candidate     = (choose_reg == CHOOSE_SEQ) ? deal_cnt_reg : lfsr_state[5:0];
        cand_in_range = (candidate < NUM_CARDS);
        cand_accept   = 1'b0;
        if (choose_reg == CHOOSE_SEQ) begin
            cand_accept = 1'b1;
        end else if (cand_in_range) begin
            cand_accept = ~used_reg[candidate];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            choose_reg   <= CHOOSE_NONE;
            used_reg     <= '0;
            deal_cnt_reg <= '0;
            tick_cnt_reg <= '0;
            card_id_reg  <= '0;
            player_reg   <= '0;
        end else begin
            state_reg    <= state_next;
            choose_reg   <= choose_next;
            used_reg     <= used_next;
            deal_cnt_reg <= deal_cnt_next;
            tick_cnt_reg <= tick_cnt_next;
            card_id_reg  <= card_id_next;
            player_reg   <= player_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        choose_next   = choose_reg;
        used_next     = used_reg;
        deal_cnt_next = deal_cnt_reg;
        tick_cnt_next = tick_cnt_reg;
        card_id_next  = card_id_reg;
        player_next   = player_reg;

        if (btn_clear) begin
            state_next    = ST_IDLE;
            choose_next   = CHOOSE_NONE;
            used_next     = '0;
            deal_cnt_next = '0;
            tick_cnt_next = '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (btn_seq) begin
                        choose_next = CHOOSE_SEQ;
                    end else if (btn_rand) begin
                        choose_next = CHOOSE_RAND;
                    end
                    if (btn_deal && (choose_reg != CHOOSE_NONE)) begin
                        used_next     = '0;
                        deal_cnt_next = '0;
                        tick_cnt_next = '0;
                        state_next    = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (frame_tick) begin
                        if (tick_cnt_reg == TICK_LAST) begin
                            tick_cnt_next = '0;
                            state_next    = ST_SEARCH;
                        end else begin
                            tick_cnt_next = tick_cnt_reg + 8'd1;
                        end
                    end
                end
                ST_SEARCH: begin
                    if (cand_accept) begin
                        card_id_next = candidate;
                        player_next  = deal_cnt_reg[1:0];
                        state_next   = ST_EMIT;
                    end
                end
                ST_EMIT: begin
                    used_next[card_id_reg] = 1'b1;
                    deal_cnt_next          = deal_cnt_reg + 6'd1;
                    state_next = (deal_cnt_reg + 6'd1 == NUM_CARDS) ? ST_DONE : ST_WAIT;
                end
                ST_DONE: begin
                    if (btn_deal) begin
                        used_next     = '0;
                        deal_cnt_next = '0;
                        tick_cnt_next = '0;
                        state_next    = ST_WAIT;
                    end
                end
                default: begin
                    state_next = ST_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        case (state_reg)
            ST_IDLE: outer_state = OUTER_RESET;
            ST_DONE: outer_state = OUTER_DONE;
            default: outer_state = OUTER_DEAL;
        endcase
    end

    assign card_valid = (state_reg == ST_EMIT);
    assign choose     = choose_reg;
    assign card_id    = card_id_reg;
    assign player     = player_reg;
    assign deal_cnt   = deal_cnt_reg;

endmodule

// File: tb/tb_deal_sequencer.sv
// Directed bench for deal_sequencer: one instance at interval 2 for full deals,
// one at interval 3 for tick-timing checks.
module tb_deal_sequencer;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       btn_seq, btn_rand, btn_deal, btn_clear, frame_tick;
    logic [1:0] outer_state, choose, player;
    logic       card_valid;
    logic [5:0] card_id, deal_cnt;

    logic       btn_seq_t, btn_rand_t, btn_deal_t, btn_clear_t, frame_tick_t;
    logic [1:0] outer_state_t, choose_t, player_t;
    logic       card_valid_t;
    logic [5:0] card_id_t, deal_cnt_t;

    int errors = 0;
    int checks = 0;
    int ids[52];
    int plyr[52];

    deal_sequencer #(.DEAL_INTERVAL(2), .LFSR_SEED(8'h01)) dut (
        .clk(clk), .rst(rst),
        .btn_seq(btn_seq), .btn_rand(btn_rand), .btn_deal(btn_deal), .btn_clear(btn_clear),
        .frame_tick(frame_tick),
        .outer_state(outer_state), .choose(choose), .card_valid(card_valid),
        .card_id(card_id), .player(player), .deal_cnt(deal_cnt)
    );

    deal_sequencer #(.DEAL_INTERVAL(3), .LFSR_SEED(8'h01)) dut_t (
        .clk(clk), .rst(rst),
        .btn_seq(btn_seq_t), .btn_rand(btn_rand_t), .btn_deal(btn_deal_t), .btn_clear(btn_clear_t),
        .frame_tick(frame_tick_t),
        .outer_state(outer_state_t), .choose(choose_t), .card_valid(card_valid_t),
        .card_id(card_id_t), .player(player_t), .deal_cnt(deal_cnt_t)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Steps until `target` cards have been dealt or the budget runs out; records payloads.
    task automatic collect(input int target, input int budget, output int n, output int max_gap);
        int gap;
        n = 0; max_gap = 0; gap = 0;
        for (int c = 0; c < budget && n < target; c++) begin
            step();
            gap++;
            if (card_valid) begin
                ids[n]  = int'(card_id);
                plyr[n] = int'(player);
                $display("card %0d: id=%0d player=%0d gap=%0d", n, card_id, player, gap);
                n++;
                if (gap > max_gap) max_gap = gap;
                gap = 0;
            end
        end
    endtask

    task automatic pulse_clear(); btn_clear = 1'b1; step(); btn_clear = 1'b0; endtask
    task automatic pulse_seq();   btn_seq   = 1'b1; step(); btn_seq   = 1'b0; endtask
    task automatic pulse_rand();  btn_rand  = 1'b1; step(); btn_rand  = 1'b0; endtask
    task automatic pulse_deal();  btn_deal  = 1'b1; step(); btn_deal  = 1'b0; endtask

    task automatic test_reset();
        rst = 1'b1;
        step(); step();
        rst = 1'b0;
        step();
        checks++; if (outer_state !== 2'd0) begin errors++; $display("FAIL reset_outer: got %0d want 0", outer_state); end
        checks++; if (choose !== 2'd0) begin errors++; $display("FAIL reset_choose: got %0d want 0", choose); end
        checks++; if (card_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b want 0", card_valid); end
        checks++; if (card_id !== 6'd0) begin errors++; $display("FAIL reset_card_id: got %0d want 0", card_id); end
        checks++; if (player !== 2'd0) begin errors++; $display("FAIL reset_player: got %0d want 0", player); end
        checks++; if (deal_cnt !== 6'd0) begin errors++; $display("FAIL reset_deal_cnt: got %0d want 0", deal_cnt); end
        $display("reset done");
    endtask

    task automatic test_buttons();
        frame_tick = 1'b0;
        pulse_deal();
        checks++; if (outer_state !== 2'd0) begin errors++; $display("FAIL deal_no_choose: outer got %0d want 0", outer_state); end
        btn_seq = 1'b1; btn_rand = 1'b1; step(); btn_seq = 1'b0; btn_rand = 1'b0;
        checks++; if (choose !== 2'd1) begin errors++; $display("FAIL seq_beats_rand: choose got %0d want 1", choose); end
        pulse_rand();
        checks++; if (choose !== 2'd2) begin errors++; $display("FAIL rand_select: choose got %0d want 2", choose); end
        btn_clear = 1'b1; btn_seq = 1'b1; step(); btn_clear = 1'b0; btn_seq = 1'b0;
        checks++; if (choose !== 2'd0) begin errors++; $display("FAIL clear_priority: choose got %0d want 0", choose); end
        pulse_seq();
        pulse_deal();
        checks++; if (outer_state !== 2'd1) begin errors++; $display("FAIL deal_start: outer got %0d want 1", outer_state); end
        pulse_rand();
        checks++; if (choose !== 2'd1) begin errors++; $display("FAIL rand_in_wait: choose got %0d want 1", choose); end
        pulse_clear();
        checks++; if (outer_state !== 2'd0 || choose !== 2'd0) begin errors++;
            $display("FAIL clear_to_idle: outer=%0d choose=%0d want 0/0", outer_state, choose); end
        $display("buttons done");
    endtask

    task automatic test_timing();
        logic stray;
        btn_seq_t = 1'b1; step(); btn_seq_t = 1'b0;
        btn_deal_t = 1'b1; step(); btn_deal_t = 1'b0;
        stray = 1'b0;
        for (int k = 0; k < 3; k++) begin
            frame_tick_t = 1'b1; step(); frame_tick_t = 1'b0;
            if (k < 2) begin
                if (card_valid_t) stray = 1'b1;
                step();
                if (card_valid_t) stray = 1'b1;
            end
        end
        // Third tick consumed: one SEARCH cycle, then EMIT.
        checks++; if (card_valid_t !== 1'b0 || stray) begin errors++;
            $display("FAIL timing_search: valid=%0b early=%0b want 0/0", card_valid_t, stray); end
        frame_tick_t = 1'b1; step();
        checks++; if (card_valid_t !== 1'b1 || card_id_t !== 6'd0 || player_t !== 2'd0) begin errors++;
            $display("FAIL timing_emit0: valid=%0b id=%0d player=%0d want 1/0/0", card_valid_t, card_id_t, player_t); end
        step(); frame_tick_t = 1'b0;
        checks++; if (card_valid_t !== 1'b0) begin errors++; $display("FAIL timing_one_cycle: valid got %0b want 0", card_valid_t); end
        // Ticks during SEARCH/EMIT were dropped, so two more ticks must not trigger a deal.
        stray = 1'b0;
        for (int k = 0; k < 2; k++) begin
            frame_tick_t = 1'b1; step(); frame_tick_t = 1'b0;
            if (card_valid_t) stray = 1'b1;
        end
        for (int k = 0; k < 4; k++) begin step(); if (card_valid_t) stray = 1'b1; end
        checks++; if (stray) begin errors++; $display("FAIL timing_drop: card_valid got 1 want 0 after 2 ticks"); end
        frame_tick_t = 1'b1; step(); frame_tick_t = 1'b0;
        step();
        checks++; if (card_valid_t !== 1'b1 || card_id_t !== 6'd1 || player_t !== 2'd1) begin errors++;
            $display("FAIL timing_emit1: valid=%0b id=%0d player=%0d want 1/1/1", card_valid_t, card_id_t, player_t); end
        $display("timing done");
    endtask

    task automatic test_seq_deal();
        int n, g;
        pulse_clear(); pulse_seq(); pulse_deal();
        frame_tick = 1'b1;
        collect(52, 1000, n, g);
        step();
        frame_tick = 1'b0;
        checks++; if (n !== 52) begin errors++; $display("FAIL seq_count: got %0d cards want 52", n); end
        for (int i = 0; i < n; i++) begin
            checks++; if (ids[i] !== i || plyr[i] !== i % 4) begin errors++;
                $display("FAIL seq_card%0d: id=%0d player=%0d want %0d/%0d", i, ids[i], plyr[i], i, i % 4); end
        end
        checks++; if (g !== 4) begin errors++; $display("FAIL seq_gap: max gap got %0d want 4", g); end
        checks++; if (outer_state !== 2'd2 || deal_cnt !== 6'd52 || card_valid !== 1'b0) begin errors++;
            $display("FAIL seq_done: outer=%0d cnt=%0d valid=%0b want 2/52/0", outer_state, deal_cnt, card_valid); end
        $display("seq deal done");
    endtask

    task automatic check_random_deal(input string tag);
        int n, g;
        int seen[52];
        frame_tick = 1'b1;
        collect(52, 20000, n, g);
        step();
        frame_tick = 1'b0;
        foreach (seen[i]) seen[i] = 0;
        for (int i = 0; i < n; i++) if (ids[i] >= 0 && ids[i] < 52) seen[ids[i]]++;
        checks++; if (n !== 52) begin errors++; $display("FAIL %s_count: got %0d cards want 52", tag, n); end
        for (int i = 0; i < 52; i++) begin
            checks++; if (seen[i] !== 1) begin errors++; $display("FAIL %s_card%0d: dealt %0d times want 1", tag, i, seen[i]); end
        end
        checks++; if (g > 257) begin errors++; $display("FAIL %s_dwell: max gap got %0d want <=257", tag, g); end
        checks++; if (outer_state !== 2'd2 || deal_cnt !== 6'd52) begin errors++;
            $display("FAIL %s_done: outer=%0d cnt=%0d want 2/52", tag, outer_state, deal_cnt); end
    endtask

    task automatic test_random_deal();
        pulse_clear(); pulse_rand(); pulse_deal();
        check_random_deal("rand");
        $display("random deal done");
    endtask

    task automatic test_restart();
        pulse_deal();
        checks++; if (outer_state !== 2'd1 || deal_cnt !== 6'd0 || choose !== 2'd2) begin errors++;
            $display("FAIL restart_start: outer=%0d cnt=%0d choose=%0d want 1/0/2", outer_state, deal_cnt, choose); end
        check_random_deal("restart");
        $display("restart done");
    endtask

    task automatic test_abort();
        int n, g;
        logic stray;
        pulse_clear(); pulse_seq(); pulse_deal();
        frame_tick = 1'b1;
        collect(10, 200, n, g);
        frame_tick = 1'b0;
        checks++; if (n !== 10) begin errors++; $display("FAIL abort_pre: got %0d cards want 10", n); end
        pulse_clear();
        checks++; if (outer_state !== 2'd0 || choose !== 2'd0 || deal_cnt !== 6'd0) begin errors++;
            $display("FAIL abort_clear: outer=%0d choose=%0d cnt=%0d want 0/0/0", outer_state, choose, deal_cnt); end
        pulse_rand(); pulse_deal();
        frame_tick = 1'b1;
        step(); step();
        frame_tick = 1'b0;
        checks++; if (outer_state !== 2'd1 || card_valid !== 1'b0) begin errors++;
            $display("FAIL abort_in_search: outer=%0d valid=%0b want 1/0", outer_state, card_valid); end
        #2 rst = 1'b1;
        #1;
        checks++; if (outer_state !== 2'd0 || choose !== 2'd0 || card_valid !== 1'b0 ||
                      card_id !== 6'd0 || player !== 2'd0 || deal_cnt !== 6'd0) begin errors++;
            $display("FAIL abort_async_rst: outer=%0d choose=%0d valid=%0b id=%0d player=%0d cnt=%0d want all 0",
                     outer_state, choose, card_valid, card_id, player, deal_cnt); end
        step(); step();
        rst = 1'b0;
        stray = 1'b0;
        for (int k = 0; k < 4; k++) begin step(); if (card_valid || outer_state != 2'd0) stray = 1'b1; end
        checks++; if (stray) begin errors++; $display("FAIL abort_after_rst: stray activity got 1 want 0"); end
        $display("abort done");
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        btn_seq = 1'b0; btn_rand = 1'b0; btn_deal = 1'b0; btn_clear = 1'b0; frame_tick = 1'b0;
        btn_seq_t = 1'b0; btn_rand_t = 1'b0; btn_deal_t = 1'b0; btn_clear_t = 1'b0; frame_tick_t = 1'b0;
        test_reset();
        test_buttons();
        test_timing();
        test_seq_deal();
        test_random_deal();
        test_restart();
        test_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
